// File: rtl/ebus_device_port_if.sv
// EBUS connection between the EBOX side (through the top-level mux) and one device port.
// The master side drives select/function/demand; the slave side answers with xfer and read data.
interface ebus_device_port_if;
    logic [0:35] EBUS;
    logic [0:7]  EBUS_DS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand;
    logic        ebusXfer;
    logic        DEVdrivingEBUS;
    logic [0:35] DEV_EBUS;

    modport master (
        output EBUS, EBUS_DS, ebusFunc, ebusDemand,
        input  ebusXfer, DEVdrivingEBUS, DEV_EBUS
    );

    modport slave (
        input  EBUS, EBUS_DS, ebusFunc, ebusDemand,
        output ebusXfer, DEVdrivingEBUS, DEV_EBUS
    );
endinterface

// File: rtl/ebus_device_port.sv
// Device-side EBUS responder: decodes select/function, captures CONO/DATAO words,
// returns CONI/DATAI data through the top-level mux, and raises the assigned PI request.
module ebus_device_port #(
    parameter logic [0:6] DEVNUM = 7'h40
) (
    input  logic                 clk,
    input  logic                 reset,
    ebus_device_port_if.slave    bus,
    input  logic [0:32]          devStatus,
    input  logic [0:35]          devDataIn,
    input  logic                 devIntReq,
    output logic                 conoStrobe,
    output logic [0:35]          conoData,
    output logic                 dataoStrobe,
    output logic [0:35]          dataoData,
    output logic                 dataiStrobe,
    output logic [0:2]           pia,
    output logic [1:7]           piReq
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_ACK   = 2'd1;
    localparam logic [1:0] ST_RD_SETUP = 2'd2;
    localparam logic [1:0] ST_RD_ACK   = 2'd3;

    localparam logic [0:2] FN_CONO  = 3'd0;
    localparam logic [0:2] FN_CONI  = 3'd1;
    localparam logic [0:2] FN_DATAO = 3'd2;
    localparam logic [0:2] FN_DATAI = 3'd3;

    logic [1:0]  state_q, state_d;
    logic [0:35] dev_ebus_q, dev_ebus_d;
    logic [0:35] cono_data_q, cono_data_d;
    logic [0:35] datao_data_q, datao_data_d;
    logic [0:2]  pia_q, pia_d;
    logic [1:7]  pi_req_q, pi_req_d;
    logic        cono_stb_q, cono_stb_d;
    logic        datao_stb_q, datao_stb_d;
    logic        datai_stb_q, datai_stb_d;
    logic        sel;
    logic        unused_ds7;

    // DS bit 7 carries no address information for this device.
    assign unused_ds7 = bus.EBUS_DS[7];

    assign sel = bus.ebusDemand && (bus.EBUS_DS[0:6] == DEVNUM) && (bus.ebusFunc <= FN_DATAI);

    always_comb begin
        state_d      = state_q;
        dev_ebus_d   = dev_ebus_q;
        cono_data_d  = cono_data_q;
        datao_data_d = datao_data_q;
        pia_d        = pia_q;
        cono_stb_d   = 1'b0;
        datao_stb_d  = 1'b0;
        datai_stb_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel) begin
                    case (bus.ebusFunc)
                        FN_CONO: begin
                            cono_data_d = bus.EBUS;
                            pia_d       = bus.EBUS[33:35];
                            cono_stb_d  = 1'b1;
                            state_d     = ST_WR_ACK;
                        end
                        FN_DATAO: begin
                            datao_data_d = bus.EBUS;
                            datao_stb_d  = 1'b1;
                            state_d      = ST_WR_ACK;
                        end
                        FN_CONI: begin
                            dev_ebus_d = {devStatus, pia_q};
                            state_d    = ST_RD_SETUP;
                        end
                        FN_DATAI: begin
                            dev_ebus_d  = devDataIn;
                            datai_stb_d = 1'b1;
                            state_d     = ST_RD_SETUP;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WR_ACK:   if (!bus.ebusDemand) state_d = ST_IDLE;
            // One settle cycle so the registered top-level mux has DEV_EBUS before xfer.
            ST_RD_SETUP: state_d = bus.ebusDemand ? ST_RD_ACK : ST_IDLE;
            ST_RD_ACK:   if (!bus.ebusDemand) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 1; gi <= 7; gi++) begin : g_pi
            assign pi_req_d[gi] = devIntReq && (pia_q == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dev_ebus_q   <= '0;
            cono_data_q  <= '0;
            datao_data_q <= '0;
            pia_q        <= '0;
            pi_req_q     <= '0;
            cono_stb_q   <= 1'b0;
            datao_stb_q  <= 1'b0;
            datai_stb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dev_ebus_q   <= dev_ebus_d;
            cono_data_q  <= cono_data_d;
            datao_data_q <= datao_data_d;
            pia_q        <= pia_d;
            pi_req_q     <= pi_req_d;
            cono_stb_q   <= cono_stb_d;
            datao_stb_q  <= datao_stb_d;
            datai_stb_q  <= datai_stb_d;
        end
    end

    assign bus.ebusXfer       = (state_q == ST_WR_ACK) || (state_q == ST_RD_ACK);
    assign bus.DEVdrivingEBUS = (state_q == ST_RD_SETUP) || (state_q == ST_RD_ACK);
    assign bus.DEV_EBUS       = dev_ebus_q;
    assign conoStrobe         = cono_stb_q;
    assign conoData           = cono_data_q;
    assign dataoStrobe        = datao_stb_q;
    assign dataoData          = datao_data_q;
    assign dataiStrobe        = datai_stb_q;
    assign pia                = pia_q;
    assign piReq              = pi_req_q;
endmodule
